// File: rtl/round_ctrl.sv
// Whack-a-mole round sequencer: banner phase, timed play phase, round advance,
// WIN after round 3 and GAME_OVER on timeout. All timing counts 1 Hz tick pulses.
module round_ctrl #(
    parameter logic [5:0] ROUND_TICKS  = 6'd30,
    parameter logic [2:0] BANNER_TICKS = 3'd3,
    parameter logic [7:0] HIT_GOAL     = 8'd10,
    parameter logic [7:0] GOAL_STEP    = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    output logic [1:0] round,
    output logic [5:0] time_left,
    output logic [7:0] hits,
    output logic [7:0] goal,
    output logic       banner,
    output logic       mole_en,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BANNER,
        S_PLAY,
        S_OVER,
        S_WIN
    } state_t;

    state_t     r_state;
    logic [2:0] r_banner_cnt;
    logic [1:0] r_round;
    logic [5:0] r_time_left;
    logic [7:0] r_hits;
    logic       r_banner;
    logic       r_mole_en;
    logic       r_game_over;
    logic       r_win;

    logic [7:0] w_goal;
    logic [7:0] w_hits_next;
    logic [5:0] w_time_next;
    logic       w_goal_met;
    logic       w_timeout;

    assign w_goal      = HIT_GOAL + 8'(r_round) * GOAL_STEP;
    assign w_hits_next = (hit && r_hits != 8'hFF) ? r_hits + 8'd1 : r_hits;
    assign w_time_next = (tick && r_time_left != 6'd0) ? r_time_left - 6'd1 : r_time_left;
    // Goal is judged on the post-hit count so a same-cycle expiring tick loses.
    assign w_goal_met  = (w_hits_next >= w_goal);
    assign w_timeout   = tick && (r_time_left == 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_banner_cnt <= 3'd0;
            r_round      <= 2'd0;
            r_time_left  <= 6'd0;
            r_hits       <= 8'd0;
            r_banner     <= 1'b0;
            r_mole_en    <= 1'b0;
            r_game_over  <= 1'b0;
            r_win        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER, S_WIN: begin
                    if (start) begin
                        r_state      <= S_BANNER;
                        r_round      <= 2'd0;
                        r_banner_cnt <= BANNER_TICKS;
                        r_hits       <= 8'd0;
                        r_time_left  <= 6'd0;
                        r_banner     <= 1'b1;
                        r_game_over  <= 1'b0;
                        r_win        <= 1'b0;
                    end
                end
                S_BANNER: begin
                    if (tick) begin
                        if (r_banner_cnt == 3'd1) begin
                            r_state     <= S_PLAY;
                            r_time_left <= ROUND_TICKS;
                            r_hits      <= 8'd0;
                            r_banner    <= 1'b0;
                            r_mole_en   <= 1'b1;
                        end else begin
                            r_banner_cnt <= r_banner_cnt - 3'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_goal_met) begin
                        r_time_left <= w_time_next;
                        r_mole_en   <= 1'b0;
                        if (r_round != 2'd3) begin
                            r_state      <= S_BANNER;
                            r_round      <= r_round + 2'd1;
                            r_banner_cnt <= BANNER_TICKS;
                            r_hits       <= 8'd0;
                            r_banner     <= 1'b1;
                        end else begin
                            r_state <= S_WIN;
                            r_hits  <= w_hits_next;
                            r_win   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_OVER;
                        r_time_left <= 6'd0;
                        r_hits      <= w_hits_next;
                        r_mole_en   <= 1'b0;
                        r_game_over <= 1'b1;
                    end else begin
                        r_hits      <= w_hits_next;
                        r_time_left <= w_time_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign round     = r_round;
    assign time_left = r_time_left;
    assign hits      = r_hits;
    assign goal      = w_goal;
    assign banner    = r_banner;
    assign mole_en   = r_mole_en;
    assign game_over = r_game_over;
    assign win       = r_win;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed scenarios plus random traffic; a phase-level
// game model feeds an expectation queue that a separate monitor drains and compares.
module tb_round_ctrl;

    localparam int RT = 30;
    localparam int BT = 3;
    localparam int HG = 10;
    localparam int GS = 5;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       tick  = 1'b0;
    logic       hit   = 1'b0;
    logic [1:0] round;
    logic [5:0] time_left;
    logic [7:0] hits;
    logic [7:0] goal;
    logic       banner;
    logic       mole_en;
    logic       game_over;
    logic       win;

    always #5 clk = ~clk;

    round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .hit       (hit),
        .round     (round),
        .time_left (time_left),
        .hits      (hits),
        .goal      (goal),
        .banner    (banner),
        .mole_en   (mole_en),
        .game_over (game_over),
        .win       (win)
    );

    typedef struct {
        int round;
        int time_left;
        int hits;
        int goal;
        bit banner;
        bit mole_en;
        bit game_over;
        bit win;
    } exp_t;

    typedef enum {P_IDLE, P_BANNER, P_PLAY, P_OVER, P_WIN} phase_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    phase_t m_phase = P_IDLE;
    int     m_round = 0;
    int     m_tl    = 0;
    int     m_hits  = 0;
    int     m_bcnt  = 0;

    function automatic int goal_of(input int r);
        return (HG + r * GS) % 256;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.round     = m_round;
        e.time_left = m_tl;
        e.hits      = m_hits;
        e.goal      = goal_of(m_round);
        e.banner    = (m_phase == P_BANNER);
        e.mole_en   = (m_phase == P_PLAY);
        e.game_over = (m_phase == P_OVER);
        e.win       = (m_phase == P_WIN);
        return e;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_round = 0;
        m_tl    = 0;
        m_hits  = 0;
        m_bcnt  = 0;
    endfunction

    // One clock of the game rules, applied to the inputs seen at that edge.
    function automatic void model_step(input bit s, input bit t, input bit h);
        int new_hits;
        int new_tl;
        case (m_phase)
            P_IDLE, P_OVER, P_WIN: begin
                if (s) begin
                    m_phase = P_BANNER;
                    m_round = 0;
                    m_hits  = 0;
                    m_tl    = 0;
                    m_bcnt  = BT;
                end
            end
            P_BANNER: begin
                if (t) begin
                    if (m_bcnt == 1) begin
                        m_phase = P_PLAY;
                        m_tl    = RT;
                        m_hits  = 0;
                    end else begin
                        m_bcnt = m_bcnt - 1;
                    end
                end
            end
            P_PLAY: begin
                new_hits = h ? ((m_hits + 1 > 255) ? 255 : m_hits + 1) : m_hits;
                new_tl   = (t && m_tl > 0) ? m_tl - 1 : m_tl;
                if (new_hits >= goal_of(m_round)) begin
                    m_tl = new_tl;
                    if (m_round < 3) begin
                        m_phase = P_BANNER;
                        m_round = m_round + 1;
                        m_bcnt  = BT;
                        m_hits  = 0;
                    end else begin
                        m_phase = P_WIN;
                        m_hits  = new_hits;
                    end
                end else if (t && m_tl == 1) begin
                    m_phase = P_OVER;
                    m_tl    = 0;
                    m_hits  = new_hits;
                end else begin
                    m_hits = new_hits;
                    m_tl   = new_tl;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endfunction

    // Monitor: every clock edge (or async reset edge) with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({round, time_left, hits, goal, banner, mole_en, game_over, win} !==
                    {2'(e.round), 6'(e.time_left), 8'(e.hits), 8'(e.goal),
                     e.banner, e.mole_en, e.game_over, e.win}) begin
                    n_errors++;
                    $display("FAIL out t=%0t: got rnd=%0d tl=%0d hits=%0d goal=%0d ban=%b mole=%b go=%b win=%b, want rnd=%0d tl=%0d hits=%0d goal=%0d ban=%b mole=%b go=%b win=%b",
                             $time, round, time_left, hits, goal, banner, mole_en, game_over, win,
                             e.round, e.time_left, e.hits, e.goal, e.banner, e.mole_en, e.game_over, e.win);
                end else begin
                    $display("ok   t=%0t rnd=%0d tl=%0d hits=%0d goal=%0d ban=%b mole=%b go=%b win=%b",
                             $time, round, time_left, hits, goal, banner, mole_en, game_over, win);
                end
            end
        end
    end

    task automatic cyc(input bit s, input bit t, input bit h);
        @(negedge clk);
        start = s;
        tick  = t;
        hit   = h;
        model_step(s, t, h);
        exp_q.push_back(snapshot());
    endtask

    // Reset raised between clock edges; the monitor checks it before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        hit   = 1'b0;
        #2;
        model_reset();
        exp_q.push_back(snapshot());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_round(input int r);
        repeat (BT) cyc(0, 1, 0);
        repeat (goal_of(r)) cyc(0, 0, 1);
    endtask

    initial begin
        int hit_pct;

        // Reset then idle: ticks and hits without start do nothing.
        async_reset();
        repeat (5) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 1);

        // Normal advance from round 0 to round 1.
        cyc(1, 0, 0);
        clear_round(0);
        cyc(0, 0, 0);

        // Timeout in round 0 with 9 hits, then hits ignored.
        async_reset();
        cyc(1, 1, 0);
        repeat (BT) cyc(0, 1, 0);
        repeat (9) cyc(0, 0, 1);
        repeat (RT) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 1);

        // Tie-break: goal-completing hit with the expiring tick.
        cyc(1, 0, 0);
        repeat (BT) cyc(0, 1, 0);
        repeat (9) cyc(0, 0, 1);
        repeat (RT - 1) cyc(0, 1, 0);
        cyc(0, 1, 1);

        // Full win from round 1 onward; start in BANNER is ignored.
        cyc(1, 0, 0);
        for (int r = 1; r <= 3; r++) clear_round(r);
        cyc(0, 1, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // Async reset mid-play in round 2.
        clear_round(0);
        clear_round(1);
        repeat (BT) cyc(0, 1, 0);
        repeat (4) cyc(0, 0, 1);
        async_reset();

        // Random traffic with varying skill levels.
        hit_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) hit_pct = $urandom_range(2, 60);
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
            end else begin
                cyc(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 99) < hit_pct));
            end
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
